// File: rtl/pwm_pkg.sv
// Shared PWM definitions: capture FSM states and the duty scale used by the
// motor PWM generator.
package pwm_pkg;

    localparam int DUTY_W    = 7;
    localparam int PCT_SCALE = 100;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        LOST
    } cap_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing a DUTY_W-bit quotient, one bit per clock, MSB first.
// The caller guarantees num < 2**DUTY_W * den, so the remainder always fits CNT_W bits.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                     clk_50,
    input  logic                     rst,
    input  logic                     start,
    input  logic [CNT_W+DUTY_W-1:0]  num,
    input  logic [CNT_W-1:0]         den,
    output logic                     busy,
    output logic                     done,
    output logic [DUTY_W-1:0]        q
);

    localparam int ITER_W = $clog2(DUTY_W + 1);

    logic [CNT_W-1:0]  rem;
    logic [DUTY_W-1:0] low_bits;
    logic [CNT_W-1:0]  den_r;
    logic [ITER_W-1:0] iter;

    logic [CNT_W:0] rem_sh;
    logic [CNT_W:0] rem_diff;
    logic           ge;

    always_comb begin
        rem_sh   = {rem, low_bits[DUTY_W-1]};
        rem_diff = rem_sh - {1'b0, den_r};
        ge       = (rem_sh >= {1'b0, den_r});
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            rem      <= '0;
            low_bits <= '0;
            den_r    <= '0;
            iter     <= '0;
            q        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                // Upper bits of num seed the remainder; the low DUTY_W bits are shifted in.
                rem      <= num[CNT_W+DUTY_W-1:DUTY_W];
                low_bits <= num[DUTY_W-1:0];
                den_r    <= den;
                iter     <= ITER_W'(DUTY_W);
                q        <= '0;
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= ge ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                low_bits <= {low_bits[DUTY_W-2:0], 1'b0};
                q        <= {q[DUTY_W-2:0], ge};
                iter     <= iter - ITER_W'(1);
                if (iter == ITER_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_duty_capture.sv
// PWM capture: measures high time and period of pwm_in and reports duty in percent.
// state | meaning
// IDLE  | after reset, waiting for the first rise (starts timing only)
// HIGH  | input high, counting the high phase
// LOW   | input low, waiting for the rise that closes the period
// LOST  | no edge within TIMEOUT; waiting for a rise to restart
module pwm_duty_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 20000,
    parameter int MIN_PERIOD = 4
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic              pwm_in,
    output logic [DUTY_W-1:0] duty_pct,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic              duty_valid,
    output logic              signal_lost,
    output logic              overrun
);

    localparam int               NUM_W   = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);

    logic s1, s2, s3;
    logic rise, fall;

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] h_reg;
    logic [CNT_W-1:0] hold_h;
    logic [CNT_W-1:0] hold_p;

    cap_state_t state, state_nx;
    logic       latch_h, div_start, set_overrun, lost_entry, lost_high;

    logic [NUM_W-1:0]  div_num;
    logic              div_busy, div_done;
    logic [DUTY_W-1:0] div_q;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;
    assign fall = ~s2 & s3;

    always_ff @(posedge clk_50) begin
        if (rst) begin
            cnt <= '0;
        end else if (rise) begin
            cnt <= CNT_W'(1);
        end else if (cnt != CNT_TO) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Edges are tested before the timeout so a late edge always wins.
    always_comb begin
        state_nx    = state;
        latch_h     = 1'b0;
        div_start   = 1'b0;
        set_overrun = 1'b0;
        lost_entry  = 1'b0;
        lost_high   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_nx = HIGH;
            end
            HIGH: begin
                if (fall) begin
                    latch_h  = 1'b1;
                    state_nx = LOW;
                end else if (cnt == CNT_TO) begin
                    lost_entry = 1'b1;
                    lost_high  = 1'b1;
                    state_nx   = LOST;
                end
            end
            LOW: begin
                if (rise) begin
                    state_nx = HIGH;
                    if (cnt >= CNT_MIN) begin
                        if (div_busy) set_overrun = 1'b1;
                        else          div_start   = 1'b1;
                    end
                end else if (cnt == CNT_TO) begin
                    lost_entry = 1'b1;
                    state_nx   = LOST;
                end
            end
            LOST: begin
                if (rise) state_nx = HIGH;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_50) begin
        if (rst) begin
            h_reg  <= '0;
            hold_h <= '0;
            hold_p <= '0;
        end else begin
            if (latch_h) h_reg <= cnt;
            if (div_start) begin
                hold_h <= h_reg;
                hold_p <= cnt;
            end
        end
    end

    assign div_num = NUM_W'(h_reg) * NUM_W'(PCT_SCALE);

    pwm_duty_div #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk_50 (clk_50),
        .rst    (rst),
        .start  (div_start),
        .num    (div_num),
        .den    (cnt),
        .busy   (div_busy),
        .done   (div_done),
        .q      (div_q)
    );

    // A loss report overrides a divider result landing in the same cycle.
    always_ff @(posedge clk_50) begin
        if (rst) begin
            duty_pct    <= '0;
            high_cnt    <= '0;
            period_cnt  <= '0;
            duty_valid  <= 1'b0;
            signal_lost <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (lost_entry) begin
                duty_valid  <= 1'b1;
                duty_pct    <= lost_high ? DUTY_W'(PCT_SCALE) : '0;
                high_cnt    <= '0;
                period_cnt  <= '0;
                signal_lost <= 1'b1;
            end else if (div_done) begin
                duty_valid  <= 1'b1;
                duty_pct    <= div_q;
                high_cnt    <= hold_h;
                period_cnt  <= hold_p;
                signal_lost <= 1'b0;
            end
            if (set_overrun) overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Self-checking bench for pwm_duty_capture: table-driven duty vectors plus
// hand sequences for loss, overrun, glitches and reset mid-divide.
module tb_pwm_duty_capture;
    import pwm_pkg::*;

    localparam int CNT_W    = 16;
    localparam int TO       = 8000;
    localparam int MINP     = 3;
    localparam int DIV_GAP  = 8;   // rises closer than this hit a busy divider
    localparam int LAT      = 11;  // pin rise drive to duty_valid: 2 sync + 9

    logic              clk_50 = 1'b0;
    logic              rst    = 1'b1;
    logic              pwm_in = 1'b0;
    logic [DUTY_W-1:0] duty_pct;
    logic [CNT_W-1:0]  high_cnt;
    logic [CNT_W-1:0]  period_cnt;
    logic              duty_valid;
    logic              signal_lost;
    logic              overrun;

    pwm_duty_capture #(
        .CNT_W      (CNT_W),
        .TIMEOUT    (TO),
        .MIN_PERIOD (MINP)
    ) dut (
        .clk_50      (clk_50),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .duty_pct    (duty_pct),
        .high_cnt    (high_cnt),
        .period_cnt  (period_cnt),
        .duty_valid  (duty_valid),
        .signal_lost (signal_lost),
        .overrun     (overrun)
    );

    always #10 clk_50 = ~clk_50;

    longint cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int     duty;
        int     h;
        int     p;
        bit     lost;
        bit     chk_lat;
        longint rise_cyc;
    } exp_t;

    typedef struct {
        int h;
        int l;
        int n;
        int duty;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    bit     m_started;
    int     m_ph, m_pl;
    longint m_last_start;
    bit     m_overrun;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_50) begin
        if (!rst && duty_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe actual duty=%0d high=%0d period=%0d expected no strobe",
                         duty_pct, high_cnt, period_cnt);
            end else begin
                mon_e = sb.pop_front();
                check("duty_pct",    duty_pct,    mon_e.duty);
                check("high_cnt",    high_cnt,    mon_e.h);
                check("period_cnt",  period_cnt,  mon_e.p);
                check("signal_lost", signal_lost, mon_e.lost);
                if (mon_e.chk_lat) check("latency", cyc - mon_e.rise_cyc, LAT);
            end
        end
    end

    task automatic model_reset();
        m_started    = 1'b0;
        m_ph         = 0;
        m_pl         = 0;
        m_last_start = -1000;
        m_overrun    = 1'b0;
    endtask

    // Model of what a rise closes: glitch reject, then busy-divider overrun.
    task automatic rise_model(int exp_duty);
        int p;
        if (m_started) begin
            p = m_ph + m_pl;
            if (p >= MINP) begin
                if (cyc - m_last_start >= DIV_GAP) begin
                    sb.push_back('{exp_duty, m_ph, p, 1'b0, 1'b1, cyc});
                    m_last_start = cyc;
                end else begin
                    m_overrun = 1'b1;
                end
            end
        end
        m_started = 1'b1;
    endtask

    task automatic pulse(int h, int l, int exp_duty);
        rise_model(exp_duty);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk_50);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk_50);
        m_ph = h;
        m_pl = l;
    endtask

    task automatic do_reset();
        check("pending_strobes", sb.size(), 0);
        sb.delete();
        pwm_in = 1'b0;
        rst    = 1'b1;
        repeat (3) @(negedge clk_50);
        check("rst_duty_pct",    duty_pct,    0);
        check("rst_high_cnt",    high_cnt,    0);
        check("rst_period_cnt",  period_cnt,  0);
        check("rst_duty_valid",  duty_valid,  0);
        check("rst_signal_lost", signal_lost, 0);
        check("rst_overrun",     overrun,     0);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_50);
    endtask

    vec_t vecs[5];

    initial begin
        vecs = '{
            '{90,   10,   3, 90},
            '{1250, 3750, 1, 25},
            '{1,    99,   2, 1},
            '{99,   1,    2, 99},
            '{2,    1,    1, 66}
        };
        model_reset();
        @(negedge clk_50);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int k = 0; k <= vecs[i].n; k++)
                pulse(vecs[i].h, (k == vecs[i].n) ? 20 : vecs[i].l, vecs[i].duty);
            repeat (5) @(negedge clk_50);
            check("vec_pending", sb.size(), 0);
            check("vec_overrun", overrun, m_overrun);
        end

        // Stuck high: one loss strobe reporting 100 %.
        do_reset();
        sb.push_back('{100, 0, 0, 1'b1, 1'b0, 0});
        rise_model(0);
        pwm_in = 1'b1;
        repeat (TO + 50) @(negedge clk_50);
        check("lost_hi_pending", sb.size(), 0);
        check("lost_hi_flag", signal_lost, 1);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk_50);

        // Stuck low: loss reports 0 %, then recovery at 50/50, period 200.
        do_reset();
        sb.push_back('{0, 0, 0, 1'b1, 1'b0, 0});
        pulse(10, TO + 50, 0);
        check("lost_lo_pending", sb.size(), 0);
        check("lost_lo_flag", signal_lost, 1);
        check("lost_lo_duty", duty_pct, 0);
        m_started = 1'b0;
        pulse(100, 100, 50);
        check("lost_still_set", signal_lost, 1);
        pulse(100, 100, 50);
        pulse(100, 20, 50);
        check("recover_pending", sb.size(), 0);
        check("recover_flag", signal_lost, 0);

        // Back-to-back period 6 overruns the divider; accepted samples still read 50.
        do_reset();
        for (int k = 0; k < 5; k++) pulse(3, 3, 50);
        pulse(3, 20, 50);
        check("ovr_pending", sb.size(), 0);
        check("ovr_set", overrun, m_overrun);
        repeat (50) @(negedge clk_50);
        check("ovr_sticky", overrun, m_overrun);

        // Glitches after a good sample leave outputs untouched.
        do_reset();
        pulse(50, 50, 50);
        for (int k = 0; k < 6; k++) pulse(1, 1, 50);
        pulse(1, 30, 50);
        check("glitch_pending", sb.size(), 0);
        check("glitch_duty",   duty_pct,   50);
        check("glitch_high",   high_cnt,   50);
        check("glitch_period", period_cnt, 100);
        check("glitch_ovr",    overrun,    m_overrun);

        // Reset while the divider is running: no strobe, then clean restart.
        do_reset();
        pulse(50, 50, 50);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk_50);
        do_reset();
        repeat (20) @(negedge clk_50);
        pulse(60, 40, 60);
        pulse(60, 40, 60);
        pulse(60, 20, 60);
        check("post_rst_pending", sb.size(), 0);
        check("post_rst_duty",   duty_pct,   60);
        check("post_rst_period", period_cnt, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
